// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared command codes and state encodings for sys_ctrl
// Purpose: single home for the UART command bytes and both FSM encodings so
//          the controller, its transmit sequencer and any tooling agree.
// Ports:   none (package).
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR    = 8'hAA;
  localparam logic [7:0] CMD_RF_RD    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOOP = 8'hDD;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUNC,
    ALU_WAIT,
    TX_LSB,
    TX_MSB
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ARM,
    TX_HOLD,
    TX_DRAIN
  } tx_state_t;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// rtl/sys_ctrl_tx_seq.sv - one-byte UART transmit handshake sequencer
// Purpose: hands one byte to the UART transmitter and reports when the
//          transmitter has finished with it.
// Ports:   clk, rst       - clock, asynchronous active-high reset
//          start, data    - one-cycle request with the byte to send
//          busy           - transmitter busy (UART TX_BUSY)
//          tx_data, tx_valid - byte and valid towards the transmitter
//          done           - one-cycle pulse once busy has returned low
module sys_ctrl_tx_seq
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  done
);

  tx_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (start) begin
            tx_data <= data;
            state   <= TX_ARM;
          end
        end
        // Never offer a byte while the transmitter is still busy.
        TX_ARM: begin
          if (!busy) begin
            tx_valid <= 1'b1;
            state    <= TX_HOLD;
          end
        end
        // Busy going high is the transmitter's acceptance of the byte.
        TX_HOLD: begin
          if (busy) begin
            tx_valid <= 1'b0;
            state    <= TX_DRAIN;
          end
        end
        TX_DRAIN: begin
          if (!busy) begin
            done  <= 1'b1;
            state <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - UART command decoder driving register file, ALU and reply
// Purpose: decodes command frames received over UART, performs register file
//          writes/reads and ALU operations, and returns results over UART.
// Ports:   CLK, RST                      - clock, asynchronous active-high reset
//          RX_DATA, RX_VALID             - received byte stream
//          RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA - register file access
//          RF_RD_DATA, RF_RD_VALID       - register file read return
//          ALU_EN, ALU_FUN, CLK_GATE_EN  - ALU control and its clock gate
//          ALU_OUT, ALU_OUT_VALID        - ALU result
//          TX_DATA, TX_VALID, TX_BUSY    - UART transmit handshake
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VALID,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_BUSY
);

  state_t                state;
  logic                  two_bytes;
  logic [DATA_WIDTH-1:0] msb_byte;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  tx_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      two_bytes   <= 1'b0;
      msb_byte    <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == DATA_WIDTH'(CMD_RF_WR)) begin
              state <= WR_ADDR;
            end else if (RX_DATA == DATA_WIDTH'(CMD_RF_RD)) begin
              state <= RD_ADDR;
            end else if (RX_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
              CLK_GATE_EN <= 1'b1;
              state       <= OP_A;
            end else if (RX_DATA == DATA_WIDTH'(CMD_ALU_NOOP)) begin
              CLK_GATE_EN <= 1'b1;
              state       <= ALU_FUNC;
            end
          end
        end
        WR_ADDR: begin
          if (RX_VALID) begin
            RF_ADDR <= RX_DATA[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_VALID) begin
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_VALID) begin
            RF_ADDR  <= RX_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (RF_RD_VALID) begin
            tx_byte   <= RF_RD_DATA;
            tx_start  <= 1'b1;
            two_bytes <= 1'b0;
            state     <= TX_LSB;
          end
        end
        // Operands land in fixed register-file slots 0 and 1 for the ALU.
        OP_A: begin
          if (RX_VALID) begin
            RF_ADDR    <= '0;
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= OP_B;
          end
        end
        OP_B: begin
          if (RX_VALID) begin
            RF_ADDR    <= ADDR_WIDTH'(1);
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= ALU_FUNC;
          end
        end
        ALU_FUNC: begin
          if (RX_VALID) begin
            ALU_FUN <= RX_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            tx_byte     <= ALU_OUT[DATA_WIDTH-1:0];
            msb_byte    <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_start    <= 1'b1;
            two_bytes   <= 1'b1;
            CLK_GATE_EN <= 1'b0;
            state       <= TX_LSB;
          end
        end
        TX_LSB: begin
          if (tx_done) begin
            if (two_bytes) begin
              tx_byte  <= msb_byte;
              tx_start <= 1'b1;
              state    <= TX_MSB;
            end else begin
              state <= IDLE;
            end
          end
        end
        TX_MSB: begin
          if (tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sys_ctrl_tx_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx_seq (
    .clk     (CLK),
    .rst     (RST),
    .start   (tx_start),
    .data    (tx_byte),
    .busy    (TX_BUSY),
    .tx_data (TX_DATA),
    .tx_valid(TX_VALID),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - self-checking randomized bench for sys_ctrl
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic        RF_WR_EN, RF_RD_EN;
  logic [3:0]  RF_ADDR;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_VALID = 1'b0;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_BUSY = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_seen  = 0;
  int tx_exp   = 0;
  logic        tx_prev = 1'b0;
  logic [11:0] wr_exp[$];
  logic [3:0]  rd_exp[$];
  logic [7:0]  mem[16];

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
            CLK_GATE_EN, TX_DATA, TX_VALID};
  endfunction

  // Passive monitor: register-file strobes against the expected-event queues.
  initial begin
    logic [11:0] we;
    logic [3:0]  re;
    forever begin
      @(negedge CLK);
      if (RF_WR_EN || RF_RD_EN) check_eq("wr_rd_excl", 32'(RF_WR_EN && RF_RD_EN), 0);
      if (RF_WR_EN) begin
        if (wr_exp.size() == 0) check_eq("wr_unexpected", 1, 0);
        else begin
          we = wr_exp.pop_front();
          check_eq("rf_write", {RF_ADDR, RF_WR_DATA}, we);
        end
      end
      if (RF_RD_EN) begin
        if (rd_exp.size() == 0) check_eq("rd_unexpected", 1, 0);
        else begin
          re = rd_exp.pop_front();
          check_eq("rf_read_addr", RF_ADDR, re);
        end
      end
      if (TX_VALID && !tx_prev) tx_seen++;
      tx_prev = TX_VALID;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  // Acts as the UART transmitter for one byte.
  task automatic recv_tx(input logic [7:0] exp, input string tag);
    int n, hold, tail;
    n = 0;
    while (!TX_VALID && n < 60) begin @(negedge CLK); n++; end
    check_eq({tag, "_valid"}, TX_VALID, 1);
    if (!TX_VALID) return;
    check_eq({tag, "_data"}, TX_DATA, exp);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check_eq({tag, "_hold"}, {TX_VALID, TX_DATA}, {1'b1, exp});
    end
    RX_DATA  = 8'($urandom);
    RX_VALID = 1'($urandom_range(0, 1));
    TX_BUSY  = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
    check_eq({tag, "_drop"}, TX_VALID, 0);
    tail = $urandom_range(0, 3);
    for (int i = 0; i < tail; i++) begin
      @(negedge CLK);
      check_eq({tag, "_busy_quiet"}, TX_VALID, 0);
    end
    TX_BUSY = 1'b0;
  endtask

  task automatic settle();
    repeat ($urandom_range(2, 4)) @(negedge CLK);
    check_eq("wr_pending", wr_exp.size(), 0);
    check_eq("rd_pending", rd_exp.size(), 0);
    check_eq("tx_count", tx_seen, tx_exp);
    check_eq("cg_idle", CLK_GATE_EN, 0);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    wr_exp.push_back({a[3:0], d});
    mem[a[3:0]] = d;
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
  endtask

  task automatic do_rd(input logic [7:0] a, input logic junk);
    int n;
    rd_exp.push_back(a[3:0]);
    send_byte(8'hBB);
    send_byte(a);
    n = 0;
    while (!RF_RD_EN && n < 20) begin @(negedge CLK); n++; end
    check_eq("rd_en_seen", RF_RD_EN, 1);
    if (junk) send_byte(8'($urandom));
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    RF_RD_DATA  = mem[a[3:0]];
    RF_RD_VALID = 1'b1;
    @(negedge CLK);
    RF_RD_VALID = 1'b0;
    RF_RD_DATA  = 8'($urandom);
    tx_exp += 1;
    recv_tx(mem[a[3:0]], "rd_tx");
  endtask

  task automatic do_alu(input logic ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f, input logic [15:0] r,
                        input logic junk, input logic rst_msb);
    int n;
    if (ops) begin
      wr_exp.push_back({4'd0, a});
      wr_exp.push_back({4'd1, b});
      mem[0] = a;
      mem[1] = b;
      send_byte(8'hCC);
      check_eq("cg_op_a", CLK_GATE_EN, 1);
      send_byte(a);
      send_byte(b);
    end else begin
      send_byte(8'hDD);
      check_eq("cg_func", CLK_GATE_EN, 1);
    end
    send_byte(f);
    n = 0;
    while (!ALU_EN && n < 20) begin @(negedge CLK); n++; end
    check_eq("alu_en_seen", ALU_EN, 1);
    check_eq("alu_fun", ALU_FUN, f[3:0]);
    check_eq("cg_wait", CLK_GATE_EN, 1);
    @(negedge CLK);
    check_eq("alu_en_pulse", ALU_EN, 0);
    if (junk) send_byte(8'hAA);
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    ALU_OUT       = r;
    ALU_OUT_VALID = 1'b1;
    @(negedge CLK);
    ALU_OUT_VALID = 1'b0;
    ALU_OUT       = 16'($urandom);
    tx_exp += 2;
    recv_tx(r[7:0], "alu_lsb");
    if (rst_msb) begin
      n = 0;
      while (!TX_VALID && n < 60) begin @(negedge CLK); n++; end
      check_eq("msb_before_rst", {TX_VALID, TX_DATA}, {1'b1, r[15:8]});
      #2 RST = 1'b1;
      #1 check_eq("rst_mid_tx", outs(), 0);
      @(negedge CLK);
      check_eq("rst_held", outs(), 0);
      @(negedge CLK);
      RST = 1'b0;
    end else begin
      recv_tx(r[15:8], "alu_msb");
    end
  endtask

  task automatic idle_noise();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
    send_byte(b);
    RF_RD_DATA  = 8'($urandom);
    RF_RD_VALID = 1'b1;
    @(negedge CLK);
    RF_RD_VALID   = 1'b0;
    ALU_OUT       = 16'($urandom);
    ALU_OUT_VALID = 1'b1;
    @(negedge CLK);
    ALU_OUT_VALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    check_eq("reset_outputs", outs(), 0);
    RST = 1'b0;
    @(negedge CLK);

    do_wr(8'h05, 8'h3C);                                   settle();
    do_rd(8'h05, 1'b0);                                    settle();
    do_alu(1'b1, 8'h07, 8'h03, 8'h00, 16'h000A, 1'b0, 1'b0); settle();
    send_byte(8'h55);
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h1234, 1'b0, 1'b0); settle();
    do_alu(1'b0, 8'h00, 8'h00, 8'h05, 16'hBEEF, 1'b0, 1'b1); settle();
    do_wr(8'h01, 8'hFF);                                   settle();
    do_alu(1'b0, 8'h00, 8'h00, 8'h0B, 16'h5A5A, 1'b1, 1'b0); settle();
    do_rd(8'h01, 1'b1);                                    settle();

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: do_wr(8'($urandom), 8'($urandom));
        1: do_rd(8'($urandom), 1'($urandom_range(0, 1)));
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
        3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
        default: idle_noise();
      endcase
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning UART byte and register-file data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have port CLK  input  1  single clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports RX_DATA input DATA_WIDTH (received byte) and RX_VALID input 1 (one-cycle pulse per byte, from synchronizer).
REQ-006 SHALL have ports RF_WR_EN, RF_RD_EN output 1; RF_ADDR output ADDR_WIDTH; RF_WR_DATA output DATA_WIDTH (register file access).
REQ-007 SHALL have ports RF_RD_DATA input DATA_WIDTH and RF_RD_VALID input 1 (read return, one-cycle pulse).
REQ-008 SHALL have ports ALU_EN output 1, ALU_FUN output 4, CLK_GATE_EN output 1 (ALU control/clock gate enable).
REQ-009 SHALL have ports ALU_OUT input 2*DATA_WIDTH and ALU_OUT_VALID input 1 (ALU result, one-cycle pulse).
REQ-010 SHALL have ports TX_DATA output DATA_WIDTH, TX_VALID output 1, TX_BUSY input 1 (UART transmit handshake).

Function
REQ-011 SHALL decode command byte in IDLE: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte ignored, remain IDLE.
REQ-012 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_WAIT, TX_LSB, TX_MSB; advance on RX_VALID only in byte-collecting states.
REQ-013 0xAA: next byte latched as address (low ADDR_WIDTH bits), next byte driven on RF_WR_DATA with RF_WR_EN high exactly one cycle, then IDLE; no reply.
REQ-014 0xBB: next byte is address; RF_RD_EN high one cycle the cycle after; RD_WAIT until RF_RD_VALID; RF_RD_DATA captured and sent as single byte (TX_LSB), then IDLE.
REQ-015 0xCC: byte A written to RF address 0, byte B written to RF address 1 (one-cycle RF_WR_EN each), then function byte -> ALU_FUNC.
REQ-016 0xDD: next byte is function -> ALU_FUNC directly.
REQ-017 ALU_FUNC: ALU_EN high one cycle with ALU_FUN = low 4 bits of function byte; CLK_GATE_EN high from entering OP_A/ALU_FUNC through ALU_OUT_VALID, low otherwise.
REQ-018 ALU_WAIT: on ALU_OUT_VALID capture ALU_OUT; transmit low byte (TX_LSB) then high byte (TX_MSB), then IDLE.
REQ-019 TX handshake: in TX state with TX_BUSY low, drive TX_DATA and TX_VALID high; hold both until TX_BUSY sampled high, then drop TX_VALID; next byte only after TX_BUSY returns low.
REQ-020 RX_VALID pulses arriving in RD_WAIT, ALU_WAIT, TX_LSB, TX_MSB SHALL be dropped without state change.
REQ-021 RF_WR_EN and RF_RD_EN SHALL never be high in the same cycle; all outputs registered.
REQ-022 RF_RD_VALID/ALU_OUT_VALID outside their wait states SHALL be ignored.

Reset
REQ-023 RST high SHALL force IDLE and all outputs to 0 (RF_*, ALU_*, CLK_GATE_EN, TX_DATA, TX_VALID) asynchronously, including mid-frame or mid-transmission.
REQ-024 After RST release the first accepted byte SHALL be treated as a command byte.

Structure
REQ-025 Command codes 0xAA/0xBB/0xCC/0xDD and FSM state encoding SHALL live in shared package sys_ctrl_pkg.
REQ-026 Byte transmit handshake (REQ-019) SHALL be one sub-module sys_ctrl_tx_seq; rest is a single FSM.

Verification
REQ-027 RX 0xAA,0x05,0x3C -> one-cycle RF_WR_EN, RF_ADDR=5, RF_WR_DATA=0x3C; no TX_VALID.
REQ-028 RX 0xBB,0x05; RF_RD_VALID with RF_RD_DATA=0x3C -> TX_DATA=0x3C, TX_VALID held until TX_BUSY high.
REQ-029 RX 0xCC,0x07,0x03,0x00; ALU_OUT=0x000A -> RF writes addr0=0x07, addr1=0x03; ALU_FUN=0; TX bytes 0x0A then 0x00.
REQ-030 RX 0x55 then 0xDD,0x02; ALU_OUT=0x1234 -> 0x55 ignored; TX 0x34 then 0x12, second only after TX_BUSY falls.
REQ-031 RST asserted during TX_MSB with TX_VALID high -> TX_VALID=0 immediately, IDLE; following 0xAA,0x01,0xFF performs write.
REQ-032 RX byte 0xAA during ALU_WAIT -> dropped; reply sent normally; state IDLE afterward.
